// File: rtl/bram_wr_packer_pkg.sv
// Shared definitions for the BRAM write-side feeders: write FSM states and
// the beats-per-block relation between stream width and block width.
package bram_wr_packer_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        WAIT_FIN = 2'd2
    } wr_state_t;

    localparam int DEF_IN_WIDTH  = 32;
    localparam int DEF_BLK_WIDTH = 512;
    localparam int DEF_N         = DEF_BLK_WIDTH / DEF_IN_WIDTH;

    function automatic int beats_per_block(input int blk_width, input int in_width);
        return blk_width / in_width;
    endfunction

endpackage

// File: rtl/bram_wr_packer_packer.sv
// Packs narrow stream beats LSB-first into one block-wide accumulator and
// reports when a completed block is available for the hold register.
module stream_word_packer
    import bram_wr_packer_pkg::*;
#(
    parameter int IN_WIDTH  = 32,
    parameter int BLK_WIDTH = 512
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [IN_WIDTH-1:0]  beat_data,
    input  logic                 beat_accept,
    input  logic                 beat_last,
    input  logic                 take,
    output logic                 acc_full,
    output logic                 blk_ready,
    output logic [BLK_WIDTH-1:0] blk_data,
    output logic                 blk_last
);

    localparam int N     = beats_per_block(BLK_WIDTH, IN_WIDTH);
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    logic [IDX_W-1:0]     idx;
    logic [BLK_WIDTH-1:0] acc;
    logic [BLK_WIDTH-1:0] merged;
    logic                 acc_last;
    logic                 complete_now;

    // Lanes above idx are always zero because the accumulator is cleared on
    // every hand-off, so an early last beat yields a zero-filled block.
    always_comb begin
        merged = acc;
        merged[idx*IN_WIDTH +: IN_WIDTH] = beat_data;
    end

    assign complete_now = beat_accept && ((idx == IDX_W'(N - 1)) || beat_last);
    assign blk_ready    = acc_full || complete_now;
    assign blk_data     = acc_full ? acc : merged;
    assign blk_last     = acc_full ? acc_last : beat_last;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx      <= '0;
            acc      <= '0;
            acc_last <= 1'b0;
            acc_full <= 1'b0;
        end else if (take) begin
            idx      <= '0;
            acc      <= '0;
            acc_last <= 1'b0;
            acc_full <= 1'b0;
        end else if (complete_now) begin
            acc      <= merged;
            acc_last <= beat_last;
            acc_full <= 1'b1;
        end else if (beat_accept) begin
            acc <= merged;
            idx <= idx + 1'b1;
        end
    end

endmodule

// File: rtl/bram_wr_packer.sv
// Stream-to-BRAM write feeder: a hold register and a three-state write FSM
// drive the controller while the next block is packed in parallel.
module bram_wr_packer
    import bram_wr_packer_pkg::*;
#(
    parameter int IN_WIDTH  = 32,
    parameter int BLK_WIDTH = 512,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [IN_WIDTH-1:0]  s_data_i,
    input  logic                 s_valid_i,
    input  logic                 s_last_i,
    output logic                 s_ready_o,
    output logic                 wr_en_o,
    output logic                 wr_valid_o,
    output logic [BLK_WIDTH-1:0] wr_data_o,
    input  logic                 wr_finish_i,
    output logic [CNT_WIDTH-1:0] blk_cnt_o,
    output logic                 frame_done_o
);

    wr_state_t            state;
    wr_state_t            state_nxt;
    logic                 acc_full;
    logic                 blk_ready;
    logic                 blk_last;
    logic [BLK_WIDTH-1:0] blk_data;
    logic                 beat_accept;
    logic                 hold_valid;
    logic                 hold_last;
    logic [BLK_WIDTH-1:0] hold_data;
    logic                 hold_release;
    logic                 take;
    logic [CNT_WIDTH-1:0] blk_cnt;
    logic                 frame_done;

    assign s_ready_o    = !acc_full;
    assign beat_accept  = s_valid_i && s_ready_o;
    assign hold_release = (state == WAIT_FIN) && wr_finish_i;
    assign take         = blk_ready && (!hold_valid || hold_release);

    stream_word_packer #(
        .IN_WIDTH  (IN_WIDTH),
        .BLK_WIDTH (BLK_WIDTH)
    ) u_packer (
        .clk         (clk_i),
        .rst_n       (rst_i),
        .beat_data   (s_data_i),
        .beat_accept (beat_accept),
        .beat_last   (s_last_i),
        .take        (take),
        .acc_full    (acc_full),
        .blk_ready   (blk_ready),
        .blk_data    (blk_data),
        .blk_last    (blk_last)
    );

    // Data is only replaced on a take, so it stays put through the whole write.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            hold_valid <= 1'b0;
            hold_last  <= 1'b0;
            hold_data  <= '0;
        end else if (take) begin
            hold_valid <= 1'b1;
            hold_last  <= blk_last;
            hold_data  <= blk_data;
        end else if (hold_release) begin
            hold_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            blk_cnt    <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= hold_release && hold_last;
            if (hold_release) begin
                blk_cnt <= blk_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A finish with another block already packed goes straight back to ISSUE.
    always_comb begin
        state_nxt  = state;
        wr_en_o    = 1'b0;
        wr_valid_o = 1'b0;
        case (state)
            IDLE: begin
                if (hold_valid) begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                wr_en_o    = 1'b1;
                wr_valid_o = 1'b1;
                state_nxt  = WAIT_FIN;
            end
            WAIT_FIN: begin
                wr_en_o = 1'b1;
                if (wr_finish_i) begin
                    state_nxt = blk_ready ? ISSUE : IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign wr_data_o    = hold_data;
    assign blk_cnt_o    = blk_cnt;
    assign frame_done_o = frame_done;

endmodule

// File: tb/tb_bram_wr_packer.sv
// Randomized and directed bench for bram_wr_packer, checked every cycle
// against a block-queue model of the packer and controller handshake.
module tb_bram_wr_packer;

    localparam int IW = 32;
    localparam int BW = 512;
    localparam int CW = 4;
    localparam int N  = BW / IW;

    typedef struct packed {
        logic          last;
        logic [IW-1:0] d;
    } beat_t;

    typedef struct packed {
        logic          last;
        logic [BW-1:0] d;
    } blk_t;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b0;
    logic [IW-1:0] s_data_i = '0;
    logic          s_valid_i = 1'b0;
    logic          s_last_i = 1'b0;
    logic          s_ready_o;
    logic          wr_en_o;
    logic          wr_valid_o;
    logic [BW-1:0] wr_data_o;
    logic          wr_finish_i = 1'b0;
    logic [CW-1:0] blk_cnt_o;
    logic          frame_done_o;

    always #5 clk_i = ~clk_i;

    bram_wr_packer #(
        .IN_WIDTH  (IW),
        .BLK_WIDTH (BW),
        .CNT_WIDTH (CW)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .s_data_i     (s_data_i),
        .s_valid_i    (s_valid_i),
        .s_last_i     (s_last_i),
        .s_ready_o    (s_ready_o),
        .wr_en_o      (wr_en_o),
        .wr_valid_o   (wr_valid_o),
        .wr_data_o    (wr_data_o),
        .wr_finish_i  (wr_finish_i),
        .blk_cnt_o    (blk_cnt_o),
        .frame_done_o (frame_done_o)
    );

    int tests_run = 0;
    int tests_failed = 0;

    beat_t         beat_q[$];
    logic [IW-1:0] part_q[$];
    blk_t          exp_q[$];
    int            cyc = 0;
    int            formed = 0;
    int            finished = 0;
    int            issue_at = -1;
    bit            outstanding = 0;
    int            wait_cnt = 0;
    int            fin_delay = 1;
    logic          out_last = 1'b0;
    logic [BW-1:0] cur_blk = '0;
    bit            fd_exp = 0;
    logic [CW-1:0] cnt_exp = '0;

    int valid_pct = 100;
    int fin_min = 1;
    int fin_max = 1;
    int spur_pct = 0;

    int            valid_cycles[$];
    int            fin_cycles[$];
    int            done_cycles[$];
    int            fd_pulses = 0;
    int            accepted_total = 0;
    int            first_stall_beats = -1;
    logic [BW-1:0] last_data = '0;

    task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic clear_records();
        valid_cycles.delete();
        fin_cycles.delete();
        done_cycles.delete();
        fd_pulses = 0;
        accepted_total = 0;
        first_stall_beats = -1;
    endtask

    // Every-cycle comparison of DUT outputs against the block-queue model.
    task automatic checkOutput();
        blk_t b;
        bit   exp_valid;
        bit   exp_en;
        cyc++;
        exp_valid = (cyc == issue_at);
        exp_en    = exp_valid || outstanding;
        chk("s_ready", s_ready_o, ((formed - finished) < 2));
        chk("wr_valid", wr_valid_o, exp_valid);
        chk("wr_en", wr_en_o, exp_en);
        chk("blk_cnt", blk_cnt_o, cnt_exp);
        chk("frame_done", frame_done_o, fd_exp);
        if (frame_done_o) fd_pulses++;
        if (!s_ready_o && first_stall_beats < 0) first_stall_beats = accepted_total;
        if (outstanding) begin
            wait_cnt++;
            chk("wr_data_stable", wr_data_o, cur_blk);
        end
        if (wr_valid_o) begin
            valid_cycles.push_back(cyc);
            last_data = wr_data_o;
            chk("blk_available", (exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                b = exp_q.pop_front();
                chk("wr_data", wr_data_o, b.d);
                cur_blk  = b.d;
                out_last = b.last;
            end
            outstanding = 1;
            wait_cnt    = 0;
            fin_delay   = $urandom_range(fin_max, fin_min);
        end
        if (cyc == issue_at) issue_at = -1;
    endtask

    // Drives the stream and the controller side, updating the model for the coming edge.
    task automatic applyStimulus();
        bit    fin_eff = 0;
        bit    completed = 0;
        int    pend_before;
        beat_t bt;
        blk_t  nb;
        pend_before = formed - finished;
        if (outstanding && wait_cnt >= 1) begin
            fin_eff     = (wait_cnt >= fin_delay);
            wr_finish_i = fin_eff;
        end else begin
            wr_finish_i = ($urandom_range(99) < spur_pct);
        end
        if (beat_q.size() > 0 && $urandom_range(99) < valid_pct) begin
            bt        = beat_q[0];
            s_valid_i = 1'b1;
            s_data_i  = bt.d;
            s_last_i  = bt.last;
            if (s_ready_o) begin
                void'(beat_q.pop_front());
                accepted_total++;
                part_q.push_back(bt.d);
                if (bt.last || part_q.size() == N) begin
                    nb.d    = '0;
                    nb.last = bt.last;
                    for (int i = 0; i < part_q.size(); i++) nb.d[i*IW +: IW] = part_q[i];
                    part_q.delete();
                    exp_q.push_back(nb);
                    formed++;
                    completed = 1;
                end
            end
        end else begin
            s_valid_i = 1'b0;
            s_data_i  = $urandom;
            s_last_i  = 1'($urandom_range(1));
        end
        fd_exp = 0;
        if (fin_eff) begin
            finished++;
            cnt_exp++;
            fd_exp      = out_last;
            outstanding = 0;
            fin_cycles.push_back(cyc);
        end
        if (completed) done_cycles.push_back(cyc);
        if (fin_eff && (formed - finished) >= 1) issue_at = cyc + 1;
        else if (completed && pend_before == 0) issue_at = cyc + 2;
    endtask

    task automatic step();
        @(negedge clk_i);
        checkOutput();
        applyStimulus();
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst_i       = 1'b0;
        s_valid_i   = 1'b0;
        wr_finish_i = 1'b0;
        @(negedge clk_i);
        chk("rst_ready", s_ready_o, 1);
        chk("rst_en", wr_en_o, 0);
        chk("rst_valid", wr_valid_o, 0);
        chk("rst_data", wr_data_o, 0);
        chk("rst_cnt", blk_cnt_o, 0);
        chk("rst_fd", frame_done_o, 0);
        rst_i = 1'b1;
        beat_q.delete();
        part_q.delete();
        exp_q.delete();
        formed      = 0;
        finished    = 0;
        outstanding = 0;
        wait_cnt    = 0;
        issue_at    = -1;
        fd_exp      = 0;
        cnt_exp     = '0;
        clear_records();
    endtask

    task automatic load_seq(input int base, input int count, input bit last_at_end);
        beat_t bt;
        for (int i = 0; i < count; i++) begin
            bt.d    = IW'(base + i);
            bt.last = last_at_end && (i == count - 1);
            beat_q.push_back(bt);
        end
    endtask

    task automatic run_until_idle(input int budget);
        int n = 0;
        while ((beat_q.size() > 0 || formed != finished || outstanding) && n < budget) begin
            step();
            n++;
        end
        chk("drain_in_budget", (n < budget), 1);
        repeat (2) step();
    endtask

    task automatic set_knobs(input int vp, input int fmin, input int fmax, input int sp);
        valid_pct = vp;
        fin_min   = fmin;
        fin_max   = fmax;
        spur_pct  = sp;
    endtask

    initial begin
        int n;
        beat_t bt;

        // Full 16-beat frame
        do_reset();
        set_knobs(100, 3, 3, 0);
        load_seq(1, 16, 1);
        run_until_idle(200);
        chk("t1_pulses", valid_cycles.size(), 1);
        chk("t1_lane0", last_data[31:0], 32'h1);
        chk("t1_lane15", last_data[511:480], 32'h10);
        chk("t1_cnt", blk_cnt_o, 1);
        chk("t1_fd", fd_pulses, 1);
        if (valid_cycles.size() > 0 && done_cycles.size() > 0)
            chk("t1_latency", valid_cycles[0] - done_cycles[0], 2);

        // Early last zero-fills the upper lanes
        do_reset();
        set_knobs(100, 2, 2, 0);
        load_seq(32'hA, 3, 1);
        run_until_idle(200);
        chk("t2_data", last_data, {416'b0, 32'hC, 32'hB, 32'hA});
        chk("t2_fd", fd_pulses, 1);

        // Back-pressure with slow finish
        do_reset();
        set_knobs(100, 40, 40, 0);
        load_seq(32'h100, 48, 1);
        run_until_idle(600);
        chk("t3_stall_at", first_stall_beats, 32);
        chk("t3_pulses", valid_cycles.size(), 3);
        chk("t3_cnt", blk_cnt_o, 3);
        chk("t3_last_lane", last_data[511:480], 32'h12F);
        chk("t3_fd", fd_pulses, 1);

        // Finish coinciding with the completing beat of the next block
        do_reset();
        set_knobs(100, 14, 14, 0);
        load_seq(32'h200, 32, 0);
        run_until_idle(300);
        chk("t4_pulses", valid_cycles.size(), 2);
        if (valid_cycles.size() > 1 && fin_cycles.size() > 0 && done_cycles.size() > 1) begin
            chk("t4_coincide", done_cycles[1], fin_cycles[0]);
            chk("t4_no_gap", valid_cycles[1], fin_cycles[0] + 1);
        end

        // Reset mid-block, then a clean block
        do_reset();
        set_knobs(100, 2, 2, 0);
        load_seq(32'hDEAD0000, 7, 0);
        repeat (8) step();
        do_reset();
        set_knobs(100, 2, 2, 0);
        load_seq(32'h5000, 16, 0);
        run_until_idle(200);
        chk("t5a_pulses", valid_cycles.size(), 1);
        chk("t5a_lane0", last_data[31:0], 32'h5000);
        chk("t5a_lane15", last_data[511:480], 32'h500F);

        // Reset during WAIT_FIN
        set_knobs(100, 60, 60, 0);
        load_seq(32'h6000, 16, 1);
        n = 0;
        while (!(outstanding && wait_cnt >= 3) && n < 100) begin
            step();
            n++;
        end
        chk("t5b_reached_wait", (n < 100), 1);
        do_reset();
        set_knobs(100, 2, 2, 0);
        load_seq(32'h7000, 16, 0);
        run_until_idle(200);
        chk("t5b_pulses", valid_cycles.size(), 1);
        chk("t5b_lane0", last_data[31:0], 32'h7000);
        chk("t5b_cnt", blk_cnt_o, 1);

        // Spurious finish in IDLE and ISSUE
        do_reset();
        set_knobs(100, 5, 5, 100);
        repeat (10) step();
        chk("t6_idle_cnt", blk_cnt_o, 0);
        chk("t6_idle_en", wr_en_o, 0);
        load_seq(32'h8000, 16, 1);
        run_until_idle(200);
        chk("t6_cnt", blk_cnt_o, 1);
        chk("t6_pulses", valid_cycles.size(), 1);

        // Random traffic, long enough to wrap the 4-bit block counter
        do_reset();
        set_knobs(70, 1, 6, 25);
        for (int i = 0; i < 400; i++) begin
            bt.d    = $urandom;
            bt.last = ($urandom_range(7) == 0) || (i == 399);
            beat_q.push_back(bt);
        end
        run_until_idle(6000);
        chk("rand_all_issued", exp_q.size(), 0);
        chk("rand_wrapped", (finished > 16), 1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
